// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel pair between the instruction
// and data caches. Grants one requester at a time (round-robin on ties),
// holds off reads whose line is still pending in the write buffer, issues
// the AR, assembles R beats into a line and returns it with a one-cycle pulse.
module axi_rd_arbiter #(
    parameter int unsigned BYTES_PER_LINE = 16
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        i_req,
    input  logic [31:0]                 i_addr,
    input  logic                        i_burst,
    input  logic [1:0]                  i_size,
    output logic                        i_rdy,
    output logic                        i_rvalid,
    output logic [BYTES_PER_LINE*8-1:0] i_rdata,

    input  logic                        d_req,
    input  logic [31:0]                 d_addr,
    input  logic                        d_burst,
    input  logic [1:0]                  d_size,
    output logic                        d_rdy,
    output logic                        d_rvalid,
    output logic [BYTES_PER_LINE*8-1:0] d_rdata,

    input  logic                        wr_idle,
    input  logic [31:0]                 wr_addr,
    output logic                        rd_busy,

    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,

    input  logic [3:0]                  rid,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4;
    localparam int unsigned PTR_WIDTH      = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_WIDTH     = WORDS_PER_LINE * 32;
    localparam int unsigned LINE_OFS       = $clog2(BYTES_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // last_grant encoding: 0 = I, 1 = D (also the AR ID encoding)
    state_e                  state_q, state_d;
    logic                    id_q, id_d;
    logic [31:0]             addr_q, addr_d;
    logic                    burst_q, burst_d;
    logic [1:0]              size_q, size_d;
    logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
    logic                    last_grant_q, last_grant_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;

    logic                    i_elig_c, d_elig_c;
    logic                    gnt_i_c, gnt_d_c;

    // Read/write hazard: a request waits while its line sits in the write buffer
    always_comb begin
        i_elig_c = i_req && (wr_idle || (i_addr[31:LINE_OFS] != wr_addr[31:LINE_OFS]));
        d_elig_c = d_req && (wr_idle || (d_addr[31:LINE_OFS] != wr_addr[31:LINE_OFS]));
    end

    // Round-robin grant among eligible requesters, only while idle
    always_comb begin
        gnt_i_c = 1'b0;
        gnt_d_c = 1'b0;
        if (!reset && (state_q == ST_IDLE)) begin
            gnt_i_c = i_elig_c && (!d_elig_c || last_grant_q);
            gnt_d_c = d_elig_c && (!i_elig_c || !last_grant_q);
        end
    end

    // Next-state, request latch and line assembly
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        size_d       = size_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        line_d       = line_q;
        i_rdy        = 1'b0;
        d_rdy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_i_c || gnt_d_c) begin
                    i_rdy        = gnt_i_c;
                    d_rdy        = gnt_d_c;
                    id_d         = gnt_d_c;
                    addr_d       = gnt_d_c ? d_addr  : i_addr;
                    burst_d      = gnt_d_c ? d_burst : i_burst;
                    size_d       = gnt_d_c ? d_size  : i_size;
                    ptr_d        = '0;
                    last_grant_d = gnt_d_c;
                    state_d      = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
                        if (PTR_WIDTH'(w) == ptr_q) begin
                            line_d[w*32 +: 32] = rdata;
                        end
                    end
                    ptr_d = (ptr_q == PTR_WIDTH'(WORDS_PER_LINE - 1)) ? '0
                                                                      : ptr_q + PTR_WIDTH'(1);
                    if (rlast) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            id_q         <= 1'b0;
            addr_q       <= '0;
            burst_q      <= 1'b0;
            size_q       <= '0;
            ptr_q        <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            size_q       <= size_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Line buffer is pure datapath; contents only matter after RESP
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // AR channel fields decoded from the latched request
    always_comb begin
        arvalid = (state_q == ST_AR);
        arid    = {3'b000, id_q};
        araddr  = burst_q ? {addr_q[31:LINE_OFS], {LINE_OFS{1'b0}}} : addr_q;
        arlen   = burst_q ? 8'(WORDS_PER_LINE - 1) : 8'd0;
        arsize  = burst_q ? 3'd2 : {1'b0, size_q};
        arburst = burst_q ? 2'b01 : 2'b00;
        arlock  = 2'b00;
        arcache = 4'b0000;
        arprot  = 3'b000;
    end

    // R-side handshake, response pulses and status
    always_comb begin
        rready   = (state_q == ST_R);
        i_rvalid = (state_q == ST_RESP) && !id_q;
        d_rvalid = (state_q == ST_RESP) &&  id_q;
        rd_busy  = (state_q != ST_IDLE);
        i_rdata  = line_q;
        d_rdata  = line_q;
    end

    logic unused_ok;
    assign unused_ok = ^{rid, rresp, wr_addr[LINE_OFS-1:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: request drivers, an AXI slave
// model and a scoreboard of expected grants, AR fields and returned lines.
module tb_axi_rd_arbiter;

    logic         clk;
    logic         reset;
    logic         i_req, d_req;
    logic [31:0]  i_addr, d_addr;
    logic         i_burst, d_burst;
    logic [1:0]   i_size, d_size;
    logic         i_rdy, d_rdy, i_rvalid, d_rvalid;
    logic [127:0] i_rdata, d_rdata;
    logic         wr_idle;
    logic [31:0]  wr_addr;
    logic         rd_busy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst, arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    axi_rd_arbiter #(.BYTES_PER_LINE(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst), .i_size(i_size),
        .i_rdy(i_rdy), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_burst(d_burst), .d_size(d_size),
        .d_rdy(d_rdy), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .wr_idle(wr_idle), .wr_addr(wr_addr), .rd_busy(rd_busy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  araddr;
        logic [7:0]   arlen;
        logic [2:0]   arsize;
        logic [1:0]   arburst;
        logic [127:0] beats;
        bit           single;
        int           lat;
    } exp_t;

    exp_t q_i[$];
    exp_t q_d[$];
    bit   gnt_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model of the AR fields for one request
    function automatic exp_t mk(input logic [31:0] addr, input bit burst, input logic [1:0] size,
                                input logic [127:0] beats, input int lat);
        exp_t e;
        e.araddr  = burst ? {addr[31:4], 4'h0} : addr;
        e.arlen   = burst ? 8'd3 : 8'd0;
        e.arsize  = burst ? 3'd2 : {1'b0, size};
        e.arburst = burst ? 2'd1 : 2'd0;
        e.beats   = beats;
        e.single  = !burst;
        e.lat     = lat;
        return e;
    endfunction

    function automatic exp_t peek(input bit side);
        return side ? q_d[0] : q_i[0];
    endfunction

    // Drive one request and hold it until granted
    task automatic do_req(input bit side, input logic [31:0] addr, input bit burst,
                          input logic [1:0] size, input int tmo, output int gcyc);
        if (side) begin d_req = 1'b1; d_addr = addr; d_burst = burst; d_size = size; end
        else      begin i_req = 1'b1; i_addr = addr; i_burst = burst; i_size = size; end
        gcyc = -1;
        for (int k = 0; k < tmo; k++) begin
            @(negedge clk);
            if (side ? d_rdy : i_rdy) begin
                gcyc = cyc;
                break;
            end
        end
        check_eq(side ? "d_req_granted" : "i_req_granted", gcyc >= 0, 1);
        @(posedge clk);
        #1;
        if (side) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic wait_drain(input int tmo);
        for (int k = 0; k < tmo; k++) begin
            if (q_i.size() == 0 && q_d.size() == 0 && gnt_q.size() == 0) break;
            @(posedge clk);
        end
        check_eq("drain", (q_i.size() == 0 && q_d.size() == 0 && gnt_q.size() == 0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: grants, response pulses, rd_busy
    bit cur_side = 1'b0;
    int gnt_cyc  = 0;
    int rv_cnt   = 0;
    bit busy_exp = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_exp = 1'b0;
            end else begin
                check_eq("rd_busy", rd_busy, busy_exp);
                if (i_rdy || d_rdy) begin
                    check_eq("rdy_onehot", i_rdy && d_rdy, 0);
                    check_eq("gnt_expected", gnt_q.size() > 0, 1);
                    if (gnt_q.size() > 0) check_eq("gnt_side", d_rdy, gnt_q.pop_front());
                    cur_side = d_rdy;
                    gnt_cyc  = cyc;
                    busy_exp = 1'b1;
                end
                if (i_rvalid || d_rvalid) begin
                    exp_t e;
                    rv_cnt++;
                    busy_exp = 1'b0;
                    check_eq("rvalid_onehot", i_rvalid && d_rvalid, 0);
                    check_eq("rvalid_side", d_rvalid, cur_side);
                    check_eq("rvalid_expected", d_rvalid ? (q_d.size() > 0) : (q_i.size() > 0), 1);
                    if (d_rvalid ? (q_d.size() > 0) : (q_i.size() > 0)) begin
                        e = d_rvalid ? q_d.pop_front() : q_i.pop_front();
                        if (e.lat > 0) check_eq("latency", cyc - gnt_cyc, e.lat);
                        if (e.single)
                            check_eq("rdata_word0", d_rvalid ? d_rdata[31:0] : i_rdata[31:0], e.beats[31:0]);
                        else
                            check_eq("rdata_line", d_rvalid ? d_rdata : i_rdata, e.beats);
                    end
                end
            end
        end
    end

    // AXI slave model: optional AR stall, optional gapped R beats
    int           stall_left = 0;
    bit           gap_mode   = 1'b0;
    bit           gap_ph     = 1'b0;
    bit           in_burst   = 1'b0;
    int           beat       = 0;
    int           nbeats     = 0;
    logic [127:0] sl_beats   = '0;
    exp_t         sl_e;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
        forever begin
            @(negedge clk);
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            if (reset) begin
                in_burst = 1'b0;
            end else if (in_burst) begin
                check_eq("rready", rready, 1);
                if (!(gap_mode && gap_ph)) begin
                    rvalid = 1'b1;
                    rdata  = sl_beats[beat*32 +: 32];
                    rlast  = (beat == nbeats - 1);
                    beat++;
                    if (rlast) in_burst = 1'b0;
                end
                gap_ph = !gap_ph;
            end else if (arvalid) begin
                check_eq("ar_expected", cur_side ? (q_d.size() > 0) : (q_i.size() > 0), 1);
                if (cur_side ? (q_d.size() > 0) : (q_i.size() > 0)) begin
                    sl_e = peek(cur_side);
                    check_eq("araddr",  araddr,  sl_e.araddr);
                    check_eq("arlen",   arlen,   sl_e.arlen);
                    check_eq("arsize",  arsize,  sl_e.arsize);
                    check_eq("arburst", arburst, sl_e.arburst);
                    check_eq("arid",    arid,    {3'b000, cur_side});
                    check_eq("ar_zero", {arlock, arcache, arprot}, 0);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        arready  = 1'b1;
                        in_burst = 1'b1;
                        beat     = 0;
                        nbeats   = int'(sl_e.arlen) + 1;
                        sl_beats = sl_e.beats;
                        gap_ph   = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int gd, gi, rise_cyc, rv0;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; i_burst = 1'b0; i_size = '0;
        d_req = 1'b0; d_addr = '0; d_burst = 1'b0; d_size = '0;
        wr_idle = 1'b1; wr_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_busy", rd_busy, 0);
        check_eq("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        check_eq("rst_rdy", {i_rdy, d_rdy}, 0);

        // simultaneous requests: D, I, D, I
        q_d.push_back(mk(32'h1000_0100, 1, 2'd2, {32'hD13, 32'hD12, 32'hD11, 32'hD10}, 6));
        q_d.push_back(mk(32'h1000_0200, 1, 2'd2, {32'hD23, 32'hD22, 32'hD21, 32'hD20}, 6));
        q_i.push_back(mk(32'h0800_0300, 1, 2'd2, {32'hE13, 32'hE12, 32'hE11, 32'hE10}, 6));
        q_i.push_back(mk(32'h0800_0400, 1, 2'd2, {32'hE23, 32'hE22, 32'hE21, 32'hE20}, 6));
        gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0);
        fork
            begin
                do_req(1, 32'h1000_0100, 1, 2'd2, 100, gd);
                do_req(1, 32'h1000_0200, 1, 2'd2, 100, gd);
            end
            begin
                do_req(0, 32'h0800_0300, 1, 2'd2, 100, gi);
                do_req(0, 32'h0800_0400, 1, 2'd2, 100, gi);
            end
        join
        wait_drain(200);

        // lone D burst
        q_d.push_back(mk(32'h1000_0014, 1, 2'd2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 6));
        gnt_q.push_back(1);
        do_req(1, 32'h1000_0014, 1, 2'd2, 50, gd);
        wait_drain(100);

        // D single word, size 1
        q_d.push_back(mk(32'h1FAF_F002, 0, 2'd1, 128'h1234, 3));
        gnt_q.push_back(1);
        do_req(1, 32'h1FAF_F002, 0, 2'd1, 50, gd);
        wait_drain(100);

        // write-buffer hazard on D; I proceeds meanwhile
        wr_idle = 1'b0;
        wr_addr = 32'h2000_0040;
        q_i.push_back(mk(32'h3000_0000, 1, 2'd2, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 6));
        q_d.push_back(mk(32'h2000_0048, 1, 2'd2, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 6));
        gnt_q.push_back(0); gnt_q.push_back(1);
        rise_cyc = -2;
        fork
            do_req(1, 32'h2000_0048, 1, 2'd2, 300, gd);
            begin
                repeat (3) @(posedge clk);
                #1;
                do_req(0, 32'h3000_0000, 1, 2'd2, 50, gi);
                for (int k = 0; k < 100 && q_i.size() != 0; k++) @(posedge clk);
                repeat (3) @(posedge clk);
                #1 wr_idle = 1'b1;
                rise_cyc = cyc;
            end
        join
        check_eq("hazard_grant_cycle", gd, rise_cyc);
        wait_drain(100);

        // AR stall plus gapped R beats
        stall_left = 5;
        gap_mode   = 1'b1;
        rv0        = rv_cnt;
        q_i.push_back(mk(32'h4000_0024, 1, 2'd2, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, 0));
        gnt_q.push_back(0);
        do_req(0, 32'h4000_0024, 1, 2'd2, 50, gi);
        wait_drain(200);
        repeat (4) @(posedge clk);
        #1;
        check_eq("single_rvalid_pulse", rv_cnt - rv0, 1);
        gap_mode = 1'b0;

        // reset while in R, then a normal transaction
        gap_mode = 1'b1;
        q_d.push_back(mk(32'h5000_0000, 1, 2'd2, {32'h7, 32'h6, 32'h5, 32'h4}, 0));
        gnt_q.push_back(1);
        do_req(1, 32'h5000_0000, 1, 2'd2, 50, gd);
        for (int k = 0; k < 20; k++) begin
            if (rready) break;
            @(posedge clk);
            #1;
        end
        check_eq("reached_r_state", rready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_rready", rready, 0);
        check_eq("rst_mid_busy", rd_busy, 0);
        check_eq("rst_mid_arvalid", arvalid, 0);
        check_eq("rst_mid_rvalid", {i_rvalid, d_rvalid}, 0);
        reset = 1'b0;
        gap_mode = 1'b0;
        q_d.delete();
        q_i.push_back(mk(32'h6000_0040, 1, 2'd2, {32'h9993, 32'h9992, 32'h9991, 32'h9990}, 6));
        gnt_q.push_back(0);
        do_req(0, 32'h6000_0040, 1, 2'd2, 50, gi);
        wait_drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
